// File: rtl/tv80_regfile_arb_pkg.sv
// Shared types for the TV80 register-file arbiter.
// State encodings, operation flag and register-pair indices.
package tv80_regarb_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HOLD = 3'd1,
    S_DUMP = 3'd2,
    S_LOAD = 3'd3,
    S_DONE = 3'd4
  } arb_state_e;

  typedef enum logic {
    OP_DUMP = 1'b0,
    OP_LOAD = 1'b1
  } arb_op_e;

  localparam int NUM_PAIRS_DEF    = 8;
  localparam int HOLD_TIMEOUT_DEF = 255;

  localparam logic [2:0] PAIR_BC = 3'd0;
  localparam logic [2:0] PAIR_DE = 3'd1;
  localparam logic [2:0] PAIR_HL = 3'd2;
  localparam logic [2:0] PAIR_IX = 3'd3;
  localparam logic [2:0] PAIR_IY = 3'd7;

endpackage

// File: rtl/tv80_regfile_arb.sv
// Shares the TV80 register-file port between the core and a
// savestate engine that dumps or loads every register pair.
module tv80_regfile_arb
  import tv80_regarb_pkg::*;
#(
  parameter int NUM_PAIRS    = NUM_PAIRS_DEF,
  parameter int HOLD_TIMEOUT = HOLD_TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  cpu_addr_a,
  input  logic [7:0]  cpu_dih,
  input  logic [7:0]  cpu_dil,
  input  logic        cpu_weh,
  input  logic        cpu_wel,
  input  logic        cpu_cen,
  output logic [2:0]  rf_addr_a,
  output logic [7:0]  rf_dih,
  output logic [7:0]  rf_dil,
  output logic        rf_weh,
  output logic        rf_wel,
  output logic        rf_cen,
  input  logic [7:0]  rf_doah,
  input  logic [7:0]  rf_doal,
  input  logic        dump_req,
  input  logic        load_req,
  output logic        cpu_hold,
  input  logic        cpu_idle,
  output logic [15:0] st_data,
  output logic        st_valid,
  input  logic        st_ready,
  input  logic [15:0] ld_data,
  input  logic        ld_valid,
  output logic        ld_ready,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam logic [2:0] IDX_LAST = 3'(NUM_PAIRS - 1);
  localparam logic [7:0] TMO_LAST = 8'(HOLD_TIMEOUT - 1);

  arb_state_e state_q, state_d;
  arb_op_e    op_q, op_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] tmo_q, tmo_d;
  logic       err_q, err_d;
  logic       cpu_hold_q, cpu_hold_d;
  logic       busy_q, busy_d;
  logic       st_valid_q, st_valid_d;
  logic       ld_ready_q, ld_ready_d;
  logic       done_q, done_d;
  logic       st_hs, ld_hs;

  assign st_hs = st_valid_q & st_ready;
  assign ld_hs = ld_ready_q & ld_valid;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    idx_d   = idx_q;
    tmo_d   = tmo_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (dump_req || load_req) begin
          state_d = S_HOLD;
          op_d    = dump_req ? OP_DUMP : OP_LOAD;
          idx_d   = 3'd0;
          tmo_d   = 8'd0;
          err_d   = 1'b0;
        end
      end
      S_HOLD: begin
        if (cpu_idle) begin
          state_d = (op_q == OP_LOAD) ? S_LOAD : S_DUMP;
        end else if (tmo_q == TMO_LAST) begin
          state_d = S_DONE;
          err_d   = 1'b1;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      S_DUMP: begin
        if (st_hs) begin
          if (idx_q == IDX_LAST) state_d = S_DONE;
          else                   idx_d   = idx_q + 3'd1;
        end
      end
      S_LOAD: begin
        if (ld_hs) begin
          if (idx_q == IDX_LAST) state_d = S_DONE;
          else                   idx_d   = idx_q + 3'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake outputs are flopped from the next state so they line up
  // with the state they describe.
  always_comb begin
    cpu_hold_d = (state_d == S_HOLD) || (state_d == S_DUMP) ||
                 (state_d == S_LOAD);
    busy_d     = (state_d != S_IDLE);
    st_valid_d = (state_d == S_DUMP);
    ld_ready_d = (state_d == S_LOAD);
    done_d     = (state_d == S_DONE);
  end

  always_comb begin
    rf_addr_a = cpu_addr_a;
    rf_dih    = cpu_dih;
    rf_dil    = cpu_dil;
    rf_weh    = cpu_weh;
    rf_wel    = cpu_wel;
    rf_cen    = cpu_cen;
    if (state_q == S_DUMP) begin
      rf_addr_a = idx_q;
      rf_dih    = 8'h00;
      rf_dil    = 8'h00;
      rf_weh    = 1'b0;
      rf_wel    = 1'b0;
      rf_cen    = 1'b0;
    end else if (state_q == S_LOAD) begin
      rf_addr_a = idx_q;
      rf_dih    = ld_data[15:8];
      rf_dil    = ld_data[7:0];
      rf_weh    = ld_hs;
      rf_wel    = ld_hs;
      rf_cen    = ld_hs;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      op_q       <= OP_DUMP;
      idx_q      <= 3'd0;
      tmo_q      <= 8'd0;
      err_q      <= 1'b0;
      cpu_hold_q <= 1'b0;
      busy_q     <= 1'b0;
      st_valid_q <= 1'b0;
      ld_ready_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      idx_q      <= idx_d;
      tmo_q      <= tmo_d;
      err_q      <= err_d;
      cpu_hold_q <= cpu_hold_d;
      busy_q     <= busy_d;
      st_valid_q <= st_valid_d;
      ld_ready_q <= ld_ready_d;
      done_q     <= done_d;
    end
  end

  assign cpu_hold = cpu_hold_q;
  assign busy     = busy_q;
  assign st_valid = st_valid_q;
  assign ld_ready = ld_ready_q;
  assign done     = done_q;
  assign err      = err_q;
  assign st_data  = st_valid_q ? {rf_doah, rf_doal} : 16'h0000;

endmodule
